pc_redirect_ctrl: RTL and testbench
===================================

Name: pc_redirect_ctrl

Overview:
- Sequences every PC redirect in the core: jump unit (JAL/JALR), branch unit and trap logic.
- Arbitrates simultaneous requests by fixed priority and checks target alignment.
- Holds the chosen redirect to the IFU under a valid/ready handshake, then squashes wrong-path instructions for a programmable number of cycles.
- Sits between the execute-stage redirect sources and the IFU. Its squash output replaces the per-unit ignore-current-instruction flags.

Parameters:
- FLUSH_DEPTH, 1, squash cycles after the IFU accepts a redirect (0 to 7 legal).
- XLEN, 32, address width.

Ports:
- i_clk  in  1  core clock
- i_rst  in  1  reset, asynchronous, active-low
- jmp_req  in  1  jump unit redirect request (its pc_update_control)
- jmp_target  in  XLEN  jump target
- br_req  in  1  taken-branch request
- br_target  in  XLEN  branch target
- trap_req  in  1  trap/exception redirect
- trap_target  in  XLEN  trap vector
- fetch_ready  in  1  IFU can accept redirect this cycle
- redirect_valid  out  1  redirect_pc valid to IFU
- redirect_pc  out  XLEN  redirect address
- redirect_src  out  2  0 none, 1 jump, 2 branch, 3 trap
- squash  out  1  ignore instruction currently in execute
- misalign_exc  out  1  one-cycle pulse: selected target not 4-byte aligned
- misalign_addr  out  XLEN  offending target, held until next pulse
- busy  out  1  state != IDLE

Behaviour:
- All outputs are registered.
- Reset (async, i_rst=0) forces state IDLE, flush counter 0 and every output 0. This applies in any state: a pending redirect is dropped and no handshake completes.
- Priority: trap > branch > jump.
- Target formation: selected target with bit0 cleared. If bit1 of that value is 1, the target is misaligned.
- State IDLE, with any request:
  - Aligned target: next cycle redirect_valid=1, redirect_pc=target, redirect_src=source, squash=1. Go to HOLD. Latency is 1 cycle from request to redirect_valid.
  - Misaligned target: next cycle misalign_exc=1 for one cycle and misalign_addr=target. No redirect, squash=0, stay IDLE.
  - Trap targets are never checked for alignment.
- State HOLD:
  - redirect_valid, redirect_pc and redirect_src stay stable until fetch_ready=1. squash=1 throughout.
  - Handshake is redirect_valid && fetch_ready. After it, redirect_valid=0 next cycle and the counter loads FLUSH_DEPTH.
  - Next state after handshake: FLUSH if FLUSH_DEPTH>0. If FLUSH_DEPTH=0, go to IDLE with squash=0.
  - jmp_req and br_req are ignored in HOLD (they come from squashed instructions).
  - trap_req without handshake, and current src != 3: replace redirect_pc/src with the trap next cycle, stay in HOLD. If current src == 3, ignore it.
  - trap_req on the handshake cycle: the current redirect completes. Next cycle presents the trap redirect in HOLD with no FLUSH in between.
- State FLUSH:
  - squash=1 and the counter decrements each cycle. When the counter is 1, next state is IDLE with squash=0, so squash covers exactly FLUSH_DEPTH cycles after the handshake cycle.
  - jmp_req and br_req are ignored.
  - trap_req: aligned-trap redirect next cycle, go to HOLD, counter cleared.
- misalign_exc never coincides with redirect_valid rising.
- A request arriving the cycle after IDLE is re-entered is accepted normally, so back-to-back redirects are legal.

Test Plan:
1. Jump, fetch ready: reset, then jmp_req=1 with jmp_target=0x0000_0100 for 1 cycle, fetch_ready=1 always, FLUSH_DEPTH=1.
   - Next cycle: redirect_valid=1, redirect_pc=0x100, src=1, squash=1.
   - Following cycle: valid=0, squash=1.
   - Cycle after that: squash=0, busy=0.
2. Simultaneous requests: jmp_req, br_req and trap_req together (targets 0x100, 0x200, 0x8000_0000) -> redirect_pc=0x8000_0000, src=3.
3. Stall with trap preempt: jump to 0x40 with fetch_ready=0 for 3 cycles.
   - redirect_valid and redirect_pc stay 0x40 across the stall.
   - trap_req (0x8000_0004) during the stall -> redirect_pc changes to 0x8000_0004, src=3.
   - fetch_ready=1 -> single handshake.
4. Misaligned target: jmp_target=0x0000_0102 -> misalign_exc one-cycle pulse, misalign_addr=0x102, redirect_valid stays 0, busy stays 0.
   - jmp_target=0x0000_0101 (bit0 cleared gives 0x100) -> normal redirect to 0x100.
5. Mid-operation reset: i_rst low asynchronously in HOLD -> all outputs 0 immediately. After release, br_req (0x300) is serviced from IDLE with 1-cycle latency.
6. FLUSH_DEPTH=3: after handshake, squash stays 1 for exactly 3 more cycles.
   - br_req during FLUSH is ignored.
   - trap_req during FLUSH -> redirect_valid next cycle.

Source files
------------

// File: rtl/pc_redirect_ctrl.sv
// PC redirect sequencer: arbitrates jump/branch/trap redirects, checks target alignment,
// holds the redirect to the IFU under valid/ready, then squashes wrong-path instructions.
module pc_redirect_ctrl #(
    parameter int FLUSH_DEPTH = 1,
    parameter int XLEN        = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            jmp_req,
    input  logic [XLEN-1:0] jmp_target,
    input  logic            br_req,
    input  logic [XLEN-1:0] br_target,
    input  logic            trap_req,
    input  logic [XLEN-1:0] trap_target,
    input  logic            fetch_ready,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic [1:0]      redirect_src,
    output logic            squash,
    output logic            misalign_exc,
    output logic [XLEN-1:0] misalign_addr,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, FLUSH = 2'd2} state_t;

    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_JMP  = 2'd1;
    localparam logic [1:0] SRC_BR   = 2'd2;
    localparam logic [1:0] SRC_TRAP = 2'd3;
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_DEPTH);

    state_t          state, state_nxt;
    logic [2:0]      cnt_p0, cnt_nxt;

    logic            sel_req;
    logic [1:0]      sel_src;
    logic [XLEN-1:0] sel_tgt;
    logic            sel_misaligned;
    logic [XLEN-1:0] trap_tgt;
    logic            hs;

    logic            valid_nxt;
    logic [XLEN-1:0] pc_nxt;
    logic [1:0]      src_nxt;
    logic            squash_nxt;
    logic            exc_nxt;
    logic [XLEN-1:0] maddr_nxt;

    function automatic logic [XLEN-1:0] form_target(input logic [XLEN-1:0] t);
        return {t[XLEN-1:1], 1'b0};
    endfunction

    // Fixed-priority source selection; trap vectors bypass the alignment check.
    always_comb begin
        sel_req = trap_req | br_req | jmp_req;
        sel_src = SRC_NONE;
        sel_tgt = '0;
        if (trap_req) begin
            sel_src = SRC_TRAP;
            sel_tgt = form_target(trap_target);
        end else if (br_req) begin
            sel_src = SRC_BR;
            sel_tgt = form_target(br_target);
        end else if (jmp_req) begin
            sel_src = SRC_JMP;
            sel_tgt = form_target(jmp_target);
        end
        sel_misaligned = sel_tgt[1] && (sel_src != SRC_TRAP);
    end

    assign trap_tgt = form_target(trap_target);
    assign hs       = redirect_valid && fetch_ready;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (sel_req && !sel_misaligned) state_nxt = HOLD;
            end
            HOLD: begin
                if (hs) begin
                    if (trap_req)                  state_nxt = HOLD;
                    else if (FLUSH_LOAD != 3'd0)   state_nxt = FLUSH;
                    else                           state_nxt = IDLE;
                end
            end
            FLUSH: begin
                if (trap_req)            state_nxt = HOLD;
                else if (cnt_p0 <= 3'd1) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        valid_nxt  = redirect_valid;
        pc_nxt     = redirect_pc;
        src_nxt    = redirect_src;
        squash_nxt = squash;
        exc_nxt    = 1'b0;
        maddr_nxt  = misalign_addr;
        cnt_nxt    = cnt_p0;
        case (state)
            IDLE: begin
                valid_nxt  = 1'b0;
                src_nxt    = SRC_NONE;
                squash_nxt = 1'b0;
                cnt_nxt    = 3'd0;
                if (sel_req) begin
                    if (sel_misaligned) begin
                        exc_nxt   = 1'b1;
                        maddr_nxt = sel_tgt;
                    end else begin
                        valid_nxt  = 1'b1;
                        pc_nxt     = sel_tgt;
                        src_nxt    = sel_src;
                        squash_nxt = 1'b1;
                    end
                end
            end
            HOLD: begin
                squash_nxt = 1'b1;
                if (hs) begin
                    if (trap_req) begin
                        // Current redirect completes; the trap follows straight away.
                        valid_nxt = 1'b1;
                        pc_nxt    = trap_tgt;
                        src_nxt   = SRC_TRAP;
                        cnt_nxt   = 3'd0;
                    end else begin
                        valid_nxt  = 1'b0;
                        src_nxt    = SRC_NONE;
                        cnt_nxt    = FLUSH_LOAD;
                        squash_nxt = (FLUSH_LOAD != 3'd0);
                    end
                end else if (trap_req && (redirect_src != SRC_TRAP)) begin
                    pc_nxt  = trap_tgt;
                    src_nxt = SRC_TRAP;
                end
            end
            FLUSH: begin
                if (trap_req) begin
                    valid_nxt  = 1'b1;
                    pc_nxt     = trap_tgt;
                    src_nxt    = SRC_TRAP;
                    squash_nxt = 1'b1;
                    cnt_nxt    = 3'd0;
                end else if (cnt_p0 <= 3'd1) begin
                    squash_nxt = 1'b0;
                    cnt_nxt    = 3'd0;
                end else begin
                    squash_nxt = 1'b1;
                    cnt_nxt    = cnt_p0 - 3'd1;
                end
            end
            default: begin
                valid_nxt  = 1'b0;
                src_nxt    = SRC_NONE;
                squash_nxt = 1'b0;
                cnt_nxt    = 3'd0;
            end
        endcase
    end

    // Output register stage
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            redirect_src   <= SRC_NONE;
            squash         <= 1'b0;
            misalign_exc   <= 1'b0;
            misalign_addr  <= '0;
            busy           <= 1'b0;
            cnt_p0         <= 3'd0;
        end else begin
            redirect_valid <= valid_nxt;
            redirect_pc    <= pc_nxt;
            redirect_src   <= src_nxt;
            squash         <= squash_nxt;
            misalign_exc   <= exc_nxt;
            misalign_addr  <= maddr_nxt;
            busy           <= (state_nxt != IDLE);
            cnt_p0         <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench for pc_redirect_ctrl: two instances (FLUSH_DEPTH 1 and 3) share stimulus.
module tb_pc_redirect_ctrl;

    localparam int XLEN = 32;
    typedef logic [37:0] vec_t;

    logic            i_clk = 1'b0;
    logic            i_rst = 1'b0;
    logic            jmp_req = 1'b0, br_req = 1'b0, trap_req = 1'b0, fetch_ready = 1'b0;
    logic [XLEN-1:0] jmp_target = '0, br_target = '0, trap_target = '0;

    logic            redirect_valid_1, squash_1, misalign_exc_1, busy_1;
    logic [XLEN-1:0] redirect_pc_1, misalign_addr_1;
    logic [1:0]      redirect_src_1;
    logic            redirect_valid_3, squash_3, misalign_exc_3, busy_3;
    logic [XLEN-1:0] redirect_pc_3, misalign_addr_3;
    logic [1:0]      redirect_src_3;

    int   checks = 0;
    int   errors = 0;
    vec_t sb[$];

    always #5 i_clk = ~i_clk;

    pc_redirect_ctrl #(.FLUSH_DEPTH(1), .XLEN(XLEN)) u_d1 (
        .i_clk(i_clk), .i_rst(i_rst),
        .jmp_req(jmp_req), .jmp_target(jmp_target),
        .br_req(br_req), .br_target(br_target),
        .trap_req(trap_req), .trap_target(trap_target),
        .fetch_ready(fetch_ready),
        .redirect_valid(redirect_valid_1), .redirect_pc(redirect_pc_1),
        .redirect_src(redirect_src_1), .squash(squash_1),
        .misalign_exc(misalign_exc_1), .misalign_addr(misalign_addr_1), .busy(busy_1)
    );

    pc_redirect_ctrl #(.FLUSH_DEPTH(3), .XLEN(XLEN)) u_d3 (
        .i_clk(i_clk), .i_rst(i_rst),
        .jmp_req(jmp_req), .jmp_target(jmp_target),
        .br_req(br_req), .br_target(br_target),
        .trap_req(trap_req), .trap_target(trap_target),
        .fetch_ready(fetch_ready),
        .redirect_valid(redirect_valid_3), .redirect_pc(redirect_pc_3),
        .redirect_src(redirect_src_3), .squash(squash_3),
        .misalign_exc(misalign_exc_3), .misalign_addr(misalign_addr_3), .busy(busy_3)
    );

    // Expected vector: {valid, src, squash, exc, busy, pc}; pc/src only meaningful while valid.
    function automatic vec_t ex(input logic v, input logic [1:0] s, input logic sq,
                                input logic e, input logic b, input logic [31:0] pc);
        return {v, s, sq, e, b, pc};
    endfunction

    function automatic vec_t obs(input bit d3);
        logic v, sq, e, b;
        logic [1:0] s;
        logic [31:0] pc;
        if (d3) begin
            v = redirect_valid_3; s = redirect_src_3; sq = squash_3;
            e = misalign_exc_3; b = busy_3; pc = redirect_pc_3;
        end else begin
            v = redirect_valid_1; s = redirect_src_1; sq = squash_1;
            e = misalign_exc_1; b = busy_1; pc = redirect_pc_1;
        end
        return {v, (v ? s : 2'b00), sq, e, b, (v ? pc : 32'h0)};
    endfunction

    task automatic set_in(input logic j, input logic [31:0] jt, input logic b, input logic [31:0] bt,
                          input logic t, input logic [31:0] tt, input logic fr);
        jmp_req = j; jmp_target = jt;
        br_req = b; br_target = bt;
        trap_req = t; trap_target = tt;
        fetch_ready = fr;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        logic [69:0] got1, got3;
        #2;
        got1 = {redirect_valid_1, redirect_pc_1, redirect_src_1, squash_1, misalign_exc_1, misalign_addr_1, busy_1};
        got3 = {redirect_valid_3, redirect_pc_3, redirect_src_3, squash_3, misalign_exc_3, misalign_addr_3, busy_3};
        checks++;
        if (got1 !== '0) begin errors++; $display("FAIL reset_d1: got %h expected 0", got1); end
        checks++;
        if (got3 !== '0) begin errors++; $display("FAIL reset_d3: got %h expected 0", got3); end
        tick();
        #2 i_rst = 1'b1;
    endtask

    task automatic test_jump();
        vec_t got, exp;
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 1);
            case (i)
                0: begin jmp_req = 1; jmp_target = 32'h100; sb.push_back(ex(1, 1, 1, 0, 1, 32'h100)); end
                1: sb.push_back(ex(0, 0, 1, 0, 1, 0));
                default: sb.push_back(ex(0, 0, 0, 0, 0, 0));
            endcase
            tick();
            exp = sb.pop_front(); got = obs(0); checks++;
            if (got !== exp) begin errors++; $display("FAIL jump[%0d]: got %h expected %h", i, got, exp); end
        end
    endtask

    task automatic test_simultaneous();
        vec_t got, exp;
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 1);
            case (i)
                0: begin
                    set_in(1, 32'h100, 1, 32'h200, 1, 32'h8000_0000, 1);
                    sb.push_back(ex(1, 3, 1, 0, 1, 32'h8000_0000));
                end
                1: sb.push_back(ex(0, 0, 1, 0, 1, 0));
                default: sb.push_back(ex(0, 0, 0, 0, 0, 0));
            endcase
            tick();
            exp = sb.pop_front(); got = obs(0); checks++;
            if (got !== exp) begin errors++; $display("FAIL simultaneous[%0d]: got %h expected %h", i, got, exp); end
        end
    endtask

    task automatic test_stall();
        vec_t got, exp;
        for (int i = 0; i < 6; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0);
            case (i)
                0: begin jmp_req = 1; jmp_target = 32'h40; sb.push_back(ex(1, 1, 1, 0, 1, 32'h40)); end
                1: begin br_req = 1; br_target = 32'h500; sb.push_back(ex(1, 1, 1, 0, 1, 32'h40)); end
                2: begin trap_req = 1; trap_target = 32'h8000_0004; sb.push_back(ex(1, 3, 1, 0, 1, 32'h8000_0004)); end
                3: begin trap_req = 1; trap_target = 32'h8000_0008; sb.push_back(ex(1, 3, 1, 0, 1, 32'h8000_0004)); end
                4: begin fetch_ready = 1; sb.push_back(ex(0, 0, 1, 0, 1, 0)); end
                default: begin fetch_ready = 1; sb.push_back(ex(0, 0, 0, 0, 0, 0)); end
            endcase
            tick();
            exp = sb.pop_front(); got = obs(0); checks++;
            if (got !== exp) begin errors++; $display("FAIL stall[%0d]: got %h expected %h", i, got, exp); end
        end
    endtask

    task automatic test_misalign();
        vec_t got, exp;
        logic [31:0] exp_ma;
        exp_ma = 32'h102;
        for (int i = 0; i < 10; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 1);
            case (i)
                0: begin jmp_req = 1; jmp_target = 32'h102; sb.push_back(ex(0, 0, 0, 1, 0, 0)); end
                2: begin jmp_req = 1; jmp_target = 32'h101; sb.push_back(ex(1, 1, 1, 0, 1, 32'h100)); end
                3, 6: sb.push_back(ex(0, 0, 1, 0, 1, 0));
                5: begin trap_req = 1; trap_target = 32'h8000_0007; sb.push_back(ex(1, 3, 1, 0, 1, 32'h8000_0006)); end
                8: begin
                    set_in(1, 32'h100, 1, 32'h206, 0, 0, 1);
                    exp_ma = 32'h206;
                    sb.push_back(ex(0, 0, 0, 1, 0, 0));
                end
                default: sb.push_back(ex(0, 0, 0, 0, 0, 0));
            endcase
            tick();
            exp = sb.pop_front(); got = obs(0); checks++;
            if (got !== exp) begin errors++; $display("FAIL misalign[%0d]: got %h expected %h", i, got, exp); end
            checks++;
            if (misalign_addr_1 !== exp_ma) begin
                errors++; $display("FAIL misalign_addr[%0d]: got %h expected %h", i, misalign_addr_1, exp_ma);
            end
        end
    endtask

    task automatic test_trap_on_handshake();
        vec_t got, exp;
        for (int i = 0; i < 4; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 1);
            case (i)
                0: begin jmp_req = 1; jmp_target = 32'h100; sb.push_back(ex(1, 1, 1, 0, 1, 32'h100)); end
                1: begin trap_req = 1; trap_target = 32'h8000_0020; sb.push_back(ex(1, 3, 1, 0, 1, 32'h8000_0020)); end
                2: sb.push_back(ex(0, 0, 1, 0, 1, 0));
                default: sb.push_back(ex(0, 0, 0, 0, 0, 0));
            endcase
            tick();
            exp = sb.pop_front(); got = obs(0); checks++;
            if (got !== exp) begin errors++; $display("FAIL trap_hs[%0d]: got %h expected %h", i, got, exp); end
        end
    endtask

    task automatic test_back_to_back();
        vec_t got, exp;
        for (int i = 0; i < 6; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 1);
            case (i)
                0: begin jmp_req = 1; jmp_target = 32'h100; sb.push_back(ex(1, 1, 1, 0, 1, 32'h100)); end
                3: begin br_req = 1; br_target = 32'h140; sb.push_back(ex(1, 2, 1, 0, 1, 32'h140)); end
                1, 4: sb.push_back(ex(0, 0, 1, 0, 1, 0));
                default: sb.push_back(ex(0, 0, 0, 0, 0, 0));
            endcase
            tick();
            exp = sb.pop_front(); got = obs(0); checks++;
            if (got !== exp) begin errors++; $display("FAIL back_to_back[%0d]: got %h expected %h", i, got, exp); end
        end
    endtask

    task automatic test_reset_mid();
        vec_t got, exp;
        logic [69:0] raw;
        set_in(1, 32'h80, 0, 0, 0, 0, 0);
        sb.push_back(ex(1, 1, 1, 0, 1, 32'h80));
        tick();
        exp = sb.pop_front(); got = obs(0); checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_mid_hold: got %h expected %h", got, exp); end
        set_in(0, 0, 0, 0, 0, 0, 0);
        #2 i_rst = 1'b0;
        #1;
        raw = {redirect_valid_1, redirect_pc_1, redirect_src_1, squash_1, misalign_exc_1, misalign_addr_1, busy_1};
        checks++;
        if (raw !== '0) begin errors++; $display("FAIL reset_mid_async: got %h expected 0", raw); end
        fetch_ready = 1;
        tick();
        raw = {redirect_valid_1, redirect_pc_1, redirect_src_1, squash_1, misalign_exc_1, misalign_addr_1, busy_1};
        checks++;
        if (raw !== '0) begin errors++; $display("FAIL reset_mid_held: got %h expected 0", raw); end
        #2 i_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 1);
            case (i)
                0: begin br_req = 1; br_target = 32'h300; sb.push_back(ex(1, 2, 1, 0, 1, 32'h300)); end
                1: sb.push_back(ex(0, 0, 1, 0, 1, 0));
                default: sb.push_back(ex(0, 0, 0, 0, 0, 0));
            endcase
            tick();
            exp = sb.pop_front(); got = obs(0); checks++;
            if (got !== exp) begin errors++; $display("FAIL reset_mid_br[%0d]: got %h expected %h", i, got, exp); end
        end
    endtask

    task automatic test_flush_depth3();
        vec_t got, exp;
        set_in(0, 0, 0, 0, 0, 0, 1);
        repeat (5) tick();
        for (int i = 0; i < 12; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 1);
            case (i)
                0, 5: begin jmp_req = 1; jmp_target = 32'h200; sb.push_back(ex(1, 1, 1, 0, 1, 32'h200)); end
                2: begin br_req = 1; br_target = 32'h300; sb.push_back(ex(0, 0, 1, 0, 1, 0)); end
                7: begin trap_req = 1; trap_target = 32'h8000_0010; sb.push_back(ex(1, 3, 1, 0, 1, 32'h8000_0010)); end
                4, 11: sb.push_back(ex(0, 0, 0, 0, 0, 0));
                default: sb.push_back(ex(0, 0, 1, 0, 1, 0));
            endcase
            tick();
            exp = sb.pop_front(); got = obs(1); checks++;
            if (got !== exp) begin errors++; $display("FAIL flush3[%0d]: got %h expected %h", i, got, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_jump();
        test_simultaneous();
        test_stall();
        test_misalign();
        test_trap_on_handshake();
        test_back_to_back();
        test_reset_mid();
        test_flush_depth3();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
